// File: rtl/uop_sequencer_pkg.sv
// Shared micro-op kinds, opcode prefixes and instruction-class decode for the
// instruction expander and the decoder.
package uop_sequencer_pkg;

  localparam int UOP_BITS = 3;

  localparam logic [UOP_BITS-1:0] UOP_PASS     = 3'd0;
  localparam logic [UOP_BITS-1:0] UOP_PUSH_REG = 3'd1;
  localparam logic [UOP_BITS-1:0] UOP_POP_REG  = 3'd2;
  localparam logic [UOP_BITS-1:0] UOP_PUSH_PC  = 3'd3;
  localparam logic [UOP_BITS-1:0] UOP_JUMP     = 3'd4;

  localparam logic [7:0] OP_PUSH_LIST = 8'b0010_0001;
  localparam logic [7:0] OP_POP_LIST  = 8'b0010_0010;
  localparam logic [9:0] OP_CALL      = 10'b0010_0000_01;

  typedef enum logic [1:0] {
    CLS_PASS = 2'd0,
    CLS_PUSH = 2'd1,
    CLS_POP  = 2'd2,
    CLS_CALL = 2'd3
  } inst_cls_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } seq_state_e;

  function automatic inst_cls_e decode_cls(input logic [15:0] inst);
    inst_cls_e cls;
    cls = CLS_PASS;
    if (inst[15:8] == OP_PUSH_LIST)     cls = CLS_PUSH;
    else if (inst[15:8] == OP_POP_LIST) cls = CLS_POP;
    else if (inst[15:6] == OP_CALL)     cls = CLS_CALL;
    return cls;
  endfunction

endpackage

// File: rtl/uop_sequencer_pick.sv
// Picks the highest (i_dir_high=1) or lowest set bit of a register mask and
// returns the mask with that bit cleared. Purely combinational.
module reg_mask_pick #(
  parameter int LOG2_NR = 3
) (
  input  logic [(1<<LOG2_NR)-1:0] i_mask,
  input  logic                    i_dir_high,
  output logic [LOG2_NR-1:0]      o_idx,
  output logic [(1<<LOG2_NR)-1:0] o_remaining
);
  localparam int NR = 1 << LOG2_NR;

  // Scan order is chosen so the last hit is the wanted end of the mask.
  always_comb begin
    o_idx = '0;
    if (i_dir_high) begin
      for (int i = 0; i < NR; i++) begin
        if (i_mask[i]) o_idx = i[LOG2_NR-1:0];
      end
    end else begin
      for (int i = NR - 1; i >= 0; i--) begin
        if (i_mask[i]) o_idx = i[LOG2_NR-1:0];
      end
    end
    o_remaining        = i_mask;
    o_remaining[o_idx] = 1'b0;
  end

endmodule

// File: rtl/uop_sequencer.sv
// Expands one 16-bit instruction into 1..NR micro-ops (register-list push/pop,
// two-step call, single pass-through), one per accepted uop_done.
import uop_sequencer_pkg::*;

module uop_sequencer #(
  parameter int LOG2_NR  = 3,
  parameter int IDX_BITS = $clog2(1 << LOG2_NR)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_inst_valid,
  input  logic [15:0]         i_inst,
  output logic                o_inst_done,
  output logic                o_uop_valid,
  output logic [UOP_BITS-1:0] o_uop_kind,
  output logic [LOG2_NR-1:0]  o_uop_reg,
  output logic [IDX_BITS-1:0] o_uop_index,
  output logic                o_uop_last,
  input  logic                i_uop_done
);
  localparam int NR = 1 << LOG2_NR;

  seq_state_e          r_state, w_state_nxt;
  logic [NR-1:0]       r_pend_mask, w_pend_nxt;
  logic [IDX_BITS-1:0] r_uop_index, w_index_nxt;

  inst_cls_e           w_cls;
  logic                w_is_list;
  logic [NR-1:0]       w_inst_mask;
  logic [NR-1:0]       w_active_mask;
  logic [NR-1:0]       w_remaining;
  logic [LOG2_NR-1:0]  w_pick_idx;
  logic                w_empty;
  logic                w_advance;

  assign w_cls         = decode_cls(i_inst);
  assign w_is_list     = (w_cls == CLS_PUSH) || (w_cls == CLS_POP);
  assign w_inst_mask   = i_inst[NR-1:0];
  assign w_active_mask = (r_state == ST_BUSY) ? r_pend_mask : w_inst_mask;

  reg_mask_pick #(.LOG2_NR(LOG2_NR)) u_pick (
    .i_mask      (w_active_mask),
    .i_dir_high  (w_cls == CLS_PUSH),
    .o_idx       (w_pick_idx),
    .o_remaining (w_remaining)
  );

  // An empty list completes immediately without presenting any micro-op.
  assign w_empty = i_inst_valid && w_is_list && (r_state == ST_IDLE) && (w_inst_mask == '0);

  always_comb begin
    o_uop_valid = i_inst_valid && !w_empty;
    o_uop_index = r_uop_index;
    o_uop_kind  = UOP_PASS;
    o_uop_reg   = '0;
    o_uop_last  = 1'b1;
    case (w_cls)
      CLS_PUSH: begin
        o_uop_kind = UOP_PUSH_REG;
        o_uop_reg  = w_pick_idx;
        o_uop_last = (w_remaining == '0);
      end
      CLS_POP: begin
        o_uop_kind = UOP_POP_REG;
        o_uop_reg  = w_pick_idx;
        o_uop_last = (w_remaining == '0);
      end
      CLS_CALL: begin
        o_uop_kind = (r_uop_index == '0) ? UOP_PUSH_PC : UOP_JUMP;
        o_uop_last = (r_uop_index == IDX_BITS'(1));
      end
      default: ;
    endcase
    w_advance   = o_uop_valid && i_uop_done && !o_uop_last;
    o_inst_done = (o_uop_valid && i_uop_done && o_uop_last) || w_empty;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend_mask;
    w_index_nxt = r_uop_index;
    // Dropping inst_valid mid-sequence is an abort: the sequence is discarded.
    if (!i_inst_valid || o_inst_done) begin
      w_state_nxt = ST_IDLE;
      w_pend_nxt  = '0;
      w_index_nxt = '0;
    end else if (w_advance) begin
      w_state_nxt = ST_BUSY;
      w_pend_nxt  = w_remaining;
      w_index_nxt = r_uop_index + IDX_BITS'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_pend_mask <= '0;
      r_uop_index <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_mask <= w_pend_nxt;
      r_uop_index <= w_index_nxt;
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Bench for uop_sequencer: directed scenarios plus random instructions, each
// checked against an expected micro-op list built from the instruction encoding.
module tb_uop_sequencer;

  localparam int LOG2_NR  = 3;
  localparam int NR       = 8;
  localparam int IDX_BITS = 3;

  logic                i_clk = 1'b0;
  logic                i_reset;
  logic                i_inst_valid;
  logic [15:0]         i_inst;
  logic                o_inst_done;
  logic                o_uop_valid;
  logic [2:0]          o_uop_kind;
  logic [LOG2_NR-1:0]  o_uop_reg;
  logic [IDX_BITS-1:0] o_uop_index;
  logic                o_uop_last;
  logic                i_uop_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int kind;
    int rnum;
  } exp_uop_t;

  uop_sequencer #(.LOG2_NR(LOG2_NR), .IDX_BITS(IDX_BITS)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_inst_valid (i_inst_valid),
    .i_inst       (i_inst),
    .o_inst_done  (o_inst_done),
    .o_uop_valid  (o_uop_valid),
    .o_uop_kind   (o_uop_kind),
    .o_uop_reg    (o_uop_reg),
    .o_uop_index  (o_uop_index),
    .o_uop_last   (o_uop_last),
    .i_uop_done   (i_uop_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected micro-op list straight from the instruction-class rules.
  task automatic build_expected(input logic [15:0] inst, output exp_uop_t q[$]);
    exp_uop_t u;
    q = {};
    if (inst[15:8] == 8'h21) begin
      for (int r = NR - 1; r >= 0; r--)
        if (inst[r]) begin u.kind = 1; u.rnum = r; q.push_back(u); end
    end else if (inst[15:8] == 8'h22) begin
      for (int r = 0; r < NR; r++)
        if (inst[r]) begin u.kind = 2; u.rnum = r; q.push_back(u); end
    end else if (inst[15:6] == 10'b0010000001) begin
      u.kind = 3; u.rnum = 0; q.push_back(u);
      u.kind = 4; u.rnum = 0; q.push_back(u);
    end else begin
      u.kind = 0; u.rnum = 0; q.push_back(u);
    end
  endtask

  // mode 0: uop_done always high; 1: random uop_done; 2: 3-cycle stall on 2nd uop.
  task automatic run_inst(input logic [15:0] inst, input int mode);
    exp_uop_t q[$];
    int pos, cyc, stall;
    logic d;
    build_expected(inst, q);
    i_inst_valid = 1'b1;
    i_inst       = inst;
    i_uop_done   = 1'b0;
    if (q.size() == 0) begin
      #1;
      check("empty_valid", o_uop_valid, 0);
      check("empty_done", o_inst_done, 1);
      @(posedge i_clk); @(negedge i_clk);
      return;
    end
    pos = 0; cyc = 0; stall = 0;
    while (pos < q.size() && cyc < 200) begin
      if (mode == 0) d = 1'b1;
      else if (mode == 1) d = 1'($urandom_range(0, 1));
      else if (pos == 1 && stall < 3) begin d = 1'b0; stall++; end
      else d = 1'b1;
      i_uop_done = d;
      #1;
      check("uop_valid", o_uop_valid, 1);
      check("uop_kind", o_uop_kind, q[pos].kind);
      check("uop_reg", o_uop_reg, q[pos].rnum);
      check("uop_index", o_uop_index, pos);
      check("uop_last", o_uop_last, (pos == q.size() - 1));
      check("inst_done", o_inst_done, d && (pos == q.size() - 1));
      @(posedge i_clk); @(negedge i_clk);
      if (d) pos++;
      cyc++;
    end
    check("seq_timeout", pos, q.size());
    i_uop_done = 1'b0;
  endtask

  initial begin
    logic [15:0] rinst;
    i_reset = 1'b1; i_inst_valid = 1'b0; i_inst = 16'h0; i_uop_done = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_uop_valid", o_uop_valid, 0);
    check("rst_inst_done", o_inst_done, 0);
    check("rst_uop_index", o_uop_index, 0);
    i_reset = 1'b0;
    @(negedge i_clk);

    run_inst(16'h2192, 0);   // push r7, r4, r1
    run_inst(16'h2292, 2);   // pop r1, r4, r7 with a stall on r4
    run_inst(16'h2045, 0);   // call
    run_inst(16'h8123, 0);   // pass
    run_inst(16'h2100, 0);   // empty push list
    run_inst(16'h2200, 1);   // empty pop list
    run_inst(16'h21FF, 0);   // full mask, indices 0..7
    run_inst(16'h22FF, 1);

    // Reset mid-sequence, with uop_done high in the reset cycle.
    i_inst = 16'h21FF; i_inst_valid = 1'b1; i_uop_done = 1'b1;
    #1;
    check("rmid_first_reg", o_uop_reg, 7);
    @(posedge i_clk); @(negedge i_clk);
    check("rmid_second_idx", o_uop_index, 1);
    i_reset = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_reset = 1'b0; i_uop_done = 1'b0;
    #1;
    check("rmid_after_idx", o_uop_index, 0);
    check("rmid_after_reg", o_uop_reg, 7);
    check("rmid_after_valid", o_uop_valid, 1);
    @(negedge i_clk);
    run_inst(16'h21FF, 0);

    // Abort after 2 of 3 micro-ops.
    i_inst = 16'h2192; i_inst_valid = 1'b1; i_uop_done = 1'b1;
    #1;
    check("abort_reg0", o_uop_reg, 7);
    @(posedge i_clk); @(negedge i_clk);
    check("abort_reg1", o_uop_reg, 4);
    check("abort_done1", o_inst_done, 0);
    @(posedge i_clk); @(negedge i_clk);
    i_inst_valid = 1'b0; i_uop_done = 1'b0;
    #1;
    check("abort_valid", o_uop_valid, 0);
    check("abort_done", o_inst_done, 0);
    @(posedge i_clk); @(negedge i_clk);
    run_inst(16'h2045, 0);

    // Random instruction stream, presented back to back.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       rinst = {8'h21, 8'($urandom)};
        1:       rinst = {8'h22, 8'($urandom)};
        2:       rinst = {10'b0010000001, 6'($urandom)};
        default: rinst = 16'($urandom);
      endcase
      run_inst(rinst, int'($urandom_range(0, 2)));
    end

    i_inst_valid = 1'b0;
    @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uop_sequencer.md
# uop_sequencer

Multi-cycle instruction expander between instruction fetch and the scheduler. It is the parametrised successor of the decoder's single-bit pre-stage mechanism. It turns one 16-bit instruction into a sequence of 1..NR micro-ops, issued one at a time under a valid/done handshake. New behaviour over the pre-stage scheme:
- register-list push and pop;
- call as two micro-ops;
- pass-through of all other instructions as a single micro-op.

## Interface
Parameters:
- LOG2_NR, 3, log2 of register count; NR = 2^LOG2_NR, LOG2_NR ≤ 3.
- IDX_BITS, $clog2(NR), width of the micro-op index.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- inst_valid  in  1  instruction present; inst held stable until inst_done.
- inst  in  16  instruction word.
- inst_done  out  1  last micro-op accepted this cycle (combinational).
- uop_valid  out  1  current micro-op valid (combinational).
- uop_kind  out  `UOP_BITS  micro-op kind, one of `UOP_PASS/PUSH_REG/POP_REG/PUSH_PC/JUMP.
- uop_reg  out  LOG2_NR  register operand of PUSH_REG/POP_REG; 0 otherwise.
- uop_index  out  IDX_BITS  position of the current micro-op in its sequence, 0-based.
- uop_last  out  1  current micro-op is the final one.
- uop_done  in  1  scheduler finished the current micro-op; ignored when uop_valid=0.

## Operation
Instruction classes, decoded from inst:
- inst[15:8]=8'b00100001: push list. mask = inst[NR-1:0]. Registers are pushed highest index first.
- inst[15:8]=8'b00100010: pop list. Same mask field. Registers are popped lowest index first.
- inst[15:6]=10'b0010000001: call. Two micro-ops: PUSH_PC (index 0), then JUMP (index 1).
- All other encodings: a single PASS micro-op with uop_reg=0.

State registers:
- busy (1 bit);
- pend_mask (NR bits);
- uop_index (IDX_BITS).

Behaviour:
- Active mask = busy ? pend_mask : inst mask.
- uop_reg = highest set bit of the active mask for push, lowest set bit for pop.
- remaining = active mask with the uop_reg bit cleared.
- uop_last:
  - push/pop: remaining == 0;
  - call: uop_index == 1;
  - pass: 1.
- uop_valid = inst_valid, except for a push/pop with inst mask == 0 while idle. In that case uop_valid=0 and inst_done=1 combinationally: the instruction completes with zero micro-ops.
- inst_done = uop_valid && uop_done && uop_last, or the empty-mask case above.

On uop_valid && uop_done && !uop_last:
- busy←1;
- pend_mask←remaining;
- uop_index←uop_index+1.

On inst_done: busy←0, pend_mask←0, uop_index←0.

inst_valid low while busy is a protocol abort: busy, pend_mask and uop_index clear on the next edge and no inst_done is produced.

## Timing
- Reset values: busy=0, pend_mask=0, uop_index=0. Outputs follow from these: uop_valid=inst_valid, inst_done=0 unless inst_valid, uop_index=0.
- First micro-op has zero latency: it is valid in the same cycle inst_valid rises.
- Throughput: at most one micro-op per cycle. A k-register list with uop_done held high takes k cycles; call takes 2 cycles.
- Stall: while uop_done=0, every uop_* output is held constant.
- A new instruction may present in the cycle after inst_done. Its first micro-op uses uop_index=0.
- uop_done on the same cycle as reset is ignored. reset always wins.
- Full mask (all NR bits) gives NR micro-ops with uop_index 0..NR-1. This fits IDX_BITS without wrap.

## Structure
- Add `UOP_BITS (=3) and `UOP_PASS=0, `UOP_PUSH_REG=1, `UOP_POP_REG=2, `UOP_PUSH_PC=3, `UOP_JUMP=4 to common.vh.
- Add to common.vh the opcode-prefix constants for push list, pop list and call, so the decoder and this block share them.
- One sub-module, reg_mask_pick:
  - inputs: an NR-bit mask and a dir bit;
  - outputs: the selected index and the cleared (remaining) mask;
  - purely combinational.

## Test plan
- Push list, inst=16'h2192 (mask 8'b10010010), uop_done held high → PUSH_REG r7, r4, r1 on consecutive cycles with uop_index 0,1,2. uop_last and inst_done on the third cycle only.
- Pop list, inst=16'h2292 → POP_REG r1, r4, r7 in that order. uop_done stalled for 3 cycles on r4 → fields held constant throughout the stall.
- Call, inst=16'h2045 → PUSH_PC (index 0, uop_last=0), then JUMP (index 1, uop_last=1). inst_done on the second uop_done.
- Pass, inst=16'h8123 → single PASS micro-op, uop_reg=0, uop_last=1, inst_done in the same cycle as uop_done. Push list 16'h2100 → inst_done while uop_valid=0, zero micro-ops.
- Reset mid-sequence: reset after the first micro-op of 16'h21FF → busy=0 and uop_index=0 next cycle. Re-presenting 16'h21FF restarts at r7.
- Abort: drop inst_valid after 2 of 3 micro-ops → no inst_done. The next instruction, 16'h2045, starts at index 0 with PUSH_PC.
